execute_unit: RTL
=================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
- REQ-002 SHALL have port clock  input  1  main clock; all state updates on rising edge.
- REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-004 SHALL have port inValid  input  1  operands/op presented this cycle.
- REQ-005 SHALL have port inReady  output  1  unit can accept an operation this cycle.
- REQ-006 SHALL have port operand1  input  WIDTH  first ALU operand (register data).
- REQ-007 SHALL have port operand2  input  WIDTH  second ALU operand (register data or PC offset, already muxed upstream).
- REQ-008 SHALL have port aluOp  input  4  operation select.
- REQ-009 SHALL have port setFlags  input  1  update NZCV flags for this operation.
- REQ-010 SHALL have port result  output  WIDTH  registered operation result.
- REQ-011 SHALL have port outValid  output  1  one-cycle pulse: result valid.
- REQ-012 SHALL have ports negative, zero, carry, overflow  output  1 each  registered NZCV flags.

Function
- REQ-013 SHALL decode aluOp: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASS (operand2), 1100 NOR, 1001 LSL, 1010 LSR, 1000 MUL; any other code yields result 0, flags unchanged.
- REQ-014 SHALL accept an operation on a rising edge where inValid && inReady; operands, aluOp and setFlags captured at that edge.
- REQ-015 SHALL implement states IDLE and MUL; inReady = 1 only in IDLE.
- REQ-016 For non-MUL ops: result and flags register at the accepting edge; outValid high for the single following cycle; state stays IDLE (back-to-back acceptance allowed every cycle).
- REQ-017 For MUL: accepting edge moves IDLE->MUL; shift-add one multiplier bit per cycle for WIDTH cycles; result = low WIDTH bits of operand1*operand2 (unsigned); outValid pulses the cycle after the WIDTH-th iteration edge; state returns to IDLE at that edge, i.e. outValid high WIDTH cycles after acceptance.
- REQ-018 inValid during MUL SHALL be ignored (not captured, not queued).
- REQ-019 ADD/SUB SHALL be WIDTH-bit modular; SUB computed as operand1 + ~operand2 + 1.
- REQ-020 LSL/LSR SHALL shift operand1 by operand2[4:0] (for WIDTH=32), zero fill; shift amount 0 returns operand1.
- REQ-021 With setFlags=1: ADD/SUB update N=result[MSB], Z=(result==0), C=carry-out of the adder (SUB: 1 = no borrow), V=signed overflow; AND updates N,Z and clears C,V; all other ops leave flags unchanged.
- REQ-022 With setFlags=0, flags SHALL hold their values.
- REQ-023 result SHALL hold its last value between outValid pulses.
- REQ-024 MUL with setFlags=1 SHALL update N and Z from the final product at completion, C and V unchanged.

Reset
- REQ-025 On reset assertion (any time, incl. mid-MUL): state IDLE, result 0, outValid 0, negative/zero/carry/overflow 0, iteration counter 0; an in-progress MUL is discarded with no outValid pulse.
- REQ-026 inReady SHALL be 1 in the first cycle after reset deasserts.

Verification
- REQ-027 ADD 0x7FFFFFFF + 0x00000001, setFlags=1 -> next cycle outValid=1, result 0x80000000, N=1 Z=0 C=0 V=1.
- REQ-028 SUB 5 - 5, setFlags=1 -> result 0, Z=1 C=1 N=0 V=0; SUB 3 - 5 -> result 0xFFFFFFFE, N=1 C=0.
- REQ-029 MUL 0x0000FFFF * 0x00010001 -> inReady low 32 cycles, outValid exactly once 32 cycles after accept, result 0xFFFFFFFF; inValid pulses during MUL produce no extra outValid.
- REQ-030 Back-to-back ORR 0xF0 | 0x0F, LSL 1 << 31, NOR 0 nor 0 on consecutive cycles -> three consecutive outValid pulses, results 0xFF, 0x80000000, 0xFFFFFFFF; flags unchanged with setFlags=0.
- REQ-031 Start MUL, assert reset at iteration 10 -> outputs/flags 0 immediately, no outValid; after release a PASS of 0x1234 returns 0x1234 one cycle later.

Source files
------------

// File: rtl/execute_unit.sv
// Execute stage ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle
// shift-add multiplier, with registered result, outValid pulse and NZCV flags.
module execute_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       aluOp,
    input  logic             setFlags,
    output logic [WIDTH-1:0] result,
    output logic             outValid,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic [CNTW-1:0]   cnt;
    logic              mul_sf;

    logic              sub_op;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH:0]    sum_ext;
    logic              add_v;
    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              upd_nz;
    logic              upd_cv;
    logic              c_val;
    logic              v_val;
    logic [WIDTH-1:0]  acc_next;

    assign inReady = (state == S_IDLE);

    // SUB reuses the adder as operand1 + ~operand2 + 1; carry-out means no borrow
    assign sub_op  = (aluOp == OP_SUB);
    assign addend  = sub_op ? ~operand2 : operand2;
    assign sum_ext = {1'b0, operand1} + {1'b0, addend} + (WIDTH+1)'(sub_op);
    assign add_v   = (operand1[WIDTH-1] == addend[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != operand1[WIDTH-1]);
    assign shamt   = operand2[SHW-1:0];

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Single-cycle result and which flags the op is allowed to touch
    always_comb begin
        alu_res = '0;
        upd_nz  = 1'b0;
        upd_cv  = 1'b0;
        c_val   = 1'b0;
        v_val   = 1'b0;
        case (aluOp)
            OP_AND: begin
                alu_res = operand1 & operand2;
                upd_nz  = 1'b1;
                upd_cv  = 1'b1;
            end
            OP_ORR:  alu_res = operand1 | operand2;
            OP_ADD, OP_SUB: begin
                alu_res = sum_ext[WIDTH-1:0];
                upd_nz  = 1'b1;
                upd_cv  = 1'b1;
                c_val   = sum_ext[WIDTH];
                v_val   = add_v;
            end
            OP_PASS: alu_res = operand2;
            OP_NOR:  alu_res = ~(operand1 | operand2);
            OP_LSL:  alu_res = operand1 << shamt;
            OP_LSR:  alu_res = operand1 >> shamt;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            result   <= '0;
            outValid <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_sf   <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inValid) begin
                        if (aluOp == OP_MUL) begin
                            state  <= S_MUL;
                            mcand  <= operand1;
                            mplier <= operand2;
                            acc    <= '0;
                            cnt    <= '0;
                            mul_sf <= setFlags;
                        end else begin
                            result   <= alu_res;
                            outValid <= 1'b1;
                            if (setFlags && upd_nz) begin
                                negative <= alu_res[WIDTH-1];
                                zero     <= (alu_res == '0);
                            end
                            if (setFlags && upd_cv) begin
                                carry    <= c_val;
                                overflow <= v_val;
                            end
                        end
                    end
                end
                S_MUL: begin
                    // One multiplier bit per cycle; last iteration publishes the product
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        state    <= S_IDLE;
                        result   <= acc_next;
                        outValid <= 1'b1;
                        if (mul_sf) begin
                            negative <= acc_next[WIDTH-1];
                            zero     <= (acc_next == '0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
